// File: rtl/sb_param_ccff.sv
// sb_param_ccff: bottom-row switch block with staged, atomically committed ccff configuration
module sb_param_ccff #(
  parameter int CHAN_WIDTH = 3,
  parameter int NUM_PINS = 8
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  ccff_commit,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  input  logic [NUM_PINS-1:0]   inpad,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  output logic [CHAN_WIDTH-1:0] chanx_left_out,
  output logic                  ccff_tail,
  output logic                  cfg_loaded,
  output logic                  cfg_overflow,
  output logic                  cfg_active
);
  localparam int SEL_W = $clog2(1 + (NUM_PINS + CHAN_WIDTH - 1) / CHAN_WIDTH);
  localparam int CHAIN_LEN = CHAN_WIDTH * SEL_W;
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int EXT_W = CHAN_WIDTH * (1 << SEL_W);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_LEN);
  logic [CHAIN_LEN-1:0] sr_q, sr_d, shadow_q, shadow_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic active_q, active_d, overflow_q, overflow_d;
  logic [EXT_W-1:0] pin_ext;
  logic [SEL_W-1:0] code;
  logic [CHAN_WIDTH-1:0] left_mux;
  assign cfg_loaded = count_q == FULL;
  assign ccff_tail = sr_q[CHAIN_LEN-1];
  assign cfg_active = active_q;
  assign cfg_overflow = overflow_q;
  assign chany_top_out = chanx_left_in;
  assign chanx_left_out = active_q ? left_mux : '0;
  assign pin_ext = EXT_W'(inpad);
  // Shifting wins over commit; commit only lands on a complete, idle chain
  always_comb begin
    sr_d = sr_q;
    shadow_d = shadow_q;
    count_d = count_q;
    active_d = active_q;
    overflow_d = overflow_q;
    if (ccff_en) begin
      sr_d = {sr_q[CHAIN_LEN-2:0], ccff_head};
      count_d = cfg_loaded ? count_q : count_q + 1'b1;
      overflow_d = overflow_q | cfg_loaded;
    end else if (ccff_commit && cfg_loaded) begin
      shadow_d = sr_q;
      count_d = '0;
      overflow_d = 1'b0;
      active_d = 1'b1;
    end
  end
  // Configuration state; reset discards any partially shifted data
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      sr_q <= '0;
      shadow_q <= '0;
      count_q <= '0;
      active_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      shadow_q <= shadow_d;
      count_q <= count_d;
      active_q <= active_d;
      overflow_q <= overflow_d;
    end
  end
  // Per-track left mux; zero-padded pins make out-of-range codes read 0
  always_comb begin
    left_mux = '0;
    code = '0;
    for (int t = 0; t < CHAN_WIDTH; t++) begin
      for (int b = 0; b < SEL_W; b++) code[SEL_W-1-b] = shadow_q[t*SEL_W+b];
      left_mux[t] = chany_top_in[t];
      for (int k = 1; k < (1 << SEL_W); k++)
        if (code == SEL_W'(k)) left_mux[t] = pin_ext[t+(k-1)*CHAN_WIDTH];
    end
  end
endmodule

// File: tb/tb_sb_param_ccff.sv
// tb_sb_param_ccff: table-driven and randomized checks against a behavioural model
module tb_sb_param_ccff;
  localparam int CW = 3;
  localparam int NP = 8;
  localparam int SW = 2;
  localparam int CL = 6;
  typedef struct {
    bit rst, en, head, commit;
    bit loaded, ovf, active, tail;
  } vec_t;
  logic prog_clk = 0, prog_reset = 0, ccff_head = 0, ccff_en = 0, ccff_commit = 0;
  logic [CW-1:0] chany_top_in = '0, chanx_left_in = '0, chany_top_out, chanx_left_out;
  logic [NP-1:0] inpad = '0;
  logic ccff_tail, cfg_loaded, cfg_overflow, cfg_active;
  int pass_cnt = 0, total_cnt = 0;
  bit hist[$];
  int m_cnt = 0;
  bit m_ovf = 0, m_act = 0;
  int m_code[CW];
  vec_t tbl[23];

  sb_param_ccff dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .ccff_head(ccff_head),
    .ccff_en(ccff_en), .ccff_commit(ccff_commit), .chany_top_in(chany_top_in),
    .chanx_left_in(chanx_left_in), .inpad(inpad), .chany_top_out(chany_top_out),
    .chanx_left_out(chanx_left_out), .ccff_tail(ccff_tail), .cfg_loaded(cfg_loaded),
    .cfg_overflow(cfg_overflow), .cfg_active(cfg_active)
  );

  always #5 prog_clk = ~prog_clk;

  // i-th most recently shifted bit, zero when fewer bits have arrived since reset
  function automatic bit sr_bit(int i);
    return i < hist.size() ? hist[hist.size()-1-i] : 1'b0;
  endfunction

  function automatic logic [CW-1:0] exp_left();
    logic [CW-1:0] v = '0;
    for (int t = 0; t < CW; t++) begin
      int idx = t + (m_code[t] - 1) * CW;
      if (m_act) v[t] = m_code[t] == 0 ? chany_top_in[t] : (idx < NP ? inpad[idx] : 1'b0);
    end
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  task automatic model_edge(bit r, bit e, bit h, bit c);
    if (r) begin
      hist.delete();
      m_cnt = 0; m_ovf = 0; m_act = 0;
      for (int t = 0; t < CW; t++) m_code[t] = 0;
    end else if (e) begin
      hist.push_back(h);
      if (hist.size() > CL) void'(hist.pop_front());
      if (m_cnt == CL) m_ovf = 1; else m_cnt++;
    end else if (c && m_cnt == CL) begin
      for (int t = 0; t < CW; t++) begin
        m_code[t] = 0;
        for (int b = 0; b < SW; b++) m_code[t] = m_code[t] * 2 + int'(sr_bit(t * SW + b));
      end
      m_cnt = 0; m_ovf = 0; m_act = 1;
    end
  endtask

  task automatic check_model();
    chk("tail", ccff_tail, sr_bit(CL - 1));
    chk("loaded", cfg_loaded, m_cnt == CL);
    chk("overflow", cfg_overflow, m_ovf);
    chk("active", cfg_active, m_act);
    chk("top_out", chany_top_out, chanx_left_in);
    chk("left_out", chanx_left_out, exp_left());
  endtask

  task automatic step(bit r, bit e, bit h, bit c);
    prog_reset = r; ccff_en = e; ccff_head = h; ccff_commit = c;
    chany_top_in = CW'($urandom); chanx_left_in = CW'($urandom); inpad = NP'($urandom);
    @(posedge prog_clk);
    model_edge(r, e, h, c);
    #1;
    check_model();
  endtask

  task automatic load(logic [CL-1:0] bits);
    for (int i = CL - 1; i >= 0; i--) step(0, 1, bits[i], 0);
    step(0, 0, 0, 1);
  endtask

  initial begin
    tbl[0]  = '{0,1,1,0, 0,0,0,0};
    tbl[1]  = '{0,1,1,0, 0,0,0,0};
    tbl[2]  = '{0,1,0,0, 0,0,0,0};
    tbl[3]  = '{0,1,1,0, 0,0,0,0};
    tbl[4]  = '{0,1,1,0, 0,0,0,0};
    tbl[5]  = '{0,1,0,0, 1,0,0,1};
    tbl[6]  = '{0,0,0,1, 0,0,1,1};
    tbl[7]  = '{0,1,1,0, 0,0,1,1};
    tbl[8]  = '{0,1,0,0, 0,0,1,0};
    tbl[9]  = '{0,1,0,0, 0,0,1,1};
    tbl[10] = '{0,1,0,0, 0,0,1,1};
    tbl[11] = '{0,1,0,0, 0,0,1,0};
    tbl[12] = '{0,1,0,0, 1,0,1,1};
    tbl[13] = '{0,1,1,0, 1,1,1,0};
    tbl[14] = '{0,0,0,1, 0,0,1,0};
    tbl[15] = '{0,0,0,1, 0,0,1,0};
    tbl[16] = '{0,1,1,0, 0,0,1,0};
    tbl[17] = '{0,1,1,0, 0,0,1,0};
    tbl[18] = '{0,1,1,0, 0,0,1,0};
    tbl[19] = '{0,1,1,0, 0,0,1,0};
    tbl[20] = '{0,0,0,1, 0,0,1,0};
    tbl[21] = '{0,1,1,1, 0,0,1,1};
    tbl[22] = '{0,1,1,1, 1,0,1,1};
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    prog_reset = 0;
    chanx_left_in = 3'b101; inpad = 8'hFF; chany_top_in = 3'b111;
    #1;
    chk("t1_top_out", chany_top_out, 3'b101);
    chk("t1_left_out", chanx_left_out, 3'b000);
    chk("t1_active", cfg_active, 1'b0);
    chk("t1_tail", ccff_tail, 1'b0);
    @(negedge prog_clk);
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].head, tbl[i].commit);
      chk("tbl_loaded", cfg_loaded, tbl[i].loaded);
      chk("tbl_overflow", cfg_overflow, tbl[i].ovf);
      chk("tbl_active", cfg_active, tbl[i].active);
      chk("tbl_tail", ccff_tail, tbl[i].tail);
      if (i == 6) chk("t2_routing", chanx_left_out, {1'b0, inpad[4], inpad[0]});
      if (i == 14) chk("t4_routing", chanx_left_out, {chany_top_in[2:1], inpad[3]});
    end
    step(1, 0, 0, 0);
    load(6'($urandom));
    for (int i = 0; i < 3; i++) step(0, 1, 1'($urandom), 0);
    step(1, 0, 0, 0);
    inpad = 8'hFF; chany_top_in = 3'b111;
    #1;
    chk("t6_left_gated", chanx_left_out, 3'b000);
    chk("t6_active", cfg_active, 1'b0);
    chk("t6_loaded", cfg_loaded, 1'b0);
    load(6'b110110);
    chk("t6_restored", chanx_left_out, {1'b0, inpad[4], inpad[0]});
    load(6'b000000);
    for (int i = 0; i < 6; i++) begin
      chany_top_in = CW'($urandom);
      #1;
      chk("t3_follow", chanx_left_out, chany_top_in);
    end
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 1), 1'($urandom), $urandom_range(0, 4) == 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
